// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - Handshake/bus bundle between pc_sequencer and its environment
// Purpose: groups instruction-memory, decode, PC-block and status signals of the
//          PC sequencer so they travel as one port.
// Ports (master = sequencer side):
//   in : imem_ready, opcode[OPC_BITS], cond_true, pc_in[PC_BITS]
//   out: ir_load, pc_latch_data, pc_ctl[2], ret_sel, ret_addr[PC_BITS],
//        sp[clog2(STACK_DEPTH)+1], halted, fault
interface pc_sequencer_if #(
   parameter int PC_BITS     = 6,
   parameter int OPC_BITS    = 3,
   parameter int STACK_DEPTH = 4
);
   localparam int SP_BITS = $clog2(STACK_DEPTH) + 1;

   logic                imem_ready;
   logic [OPC_BITS-1:0] opcode;
   logic                cond_true;
   logic [PC_BITS-1:0]  pc_in;
   logic                ir_load;
   logic                pc_latch_data;
   logic [1:0]          pc_ctl;
   logic                ret_sel;
   logic [PC_BITS-1:0]  ret_addr;
   logic [SP_BITS-1:0]  sp;
   logic                halted;
   logic                fault;

   modport master (
      input  imem_ready, opcode, cond_true, pc_in,
      output ir_load, pc_latch_data, pc_ctl, ret_sel, ret_addr, sp, halted, fault
   );

   modport slave (
      output imem_ready, opcode, cond_true, pc_in,
      input  ir_load, pc_latch_data, pc_ctl, ret_sel, ret_addr, sp, halted, fault
   );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - Fetch/execute controller for the program counter
// Purpose: steps each instruction through FETCH -> EXEC -> UPDATE, issues the PC
//          update strobe/control in UPDATE and keeps a return-address stack for
//          CALL/RET. HALT and stack overflow/underflow park the controller until reset.
// Ports:
//   clka  : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : pc_sequencer_if.master (imem_ready/opcode/cond_true/pc_in in;
//           ir_load, pc_latch_data, pc_ctl, ret_sel, ret_addr, sp, halted, fault out)
module pc_sequencer #(
   parameter int PC_BITS     = 6,
   parameter int OPC_BITS    = 3,
   parameter int STACK_DEPTH = 4
) (
   input logic            clka,
   input logic            reset,
   pc_sequencer_if.master bus
);
   localparam int SP_BITS  = $clog2(STACK_DEPTH) + 1;
   localparam int IDX_BITS = $clog2(STACK_DEPTH);

   localparam logic [OPC_BITS-1:0] OP_BRANCH = OPC_BITS'(1);
   localparam logic [OPC_BITS-1:0] OP_JMPI   = OPC_BITS'(2);
   localparam logic [OPC_BITS-1:0] OP_JMPR   = OPC_BITS'(3);
   localparam logic [OPC_BITS-1:0] OP_CALL   = OPC_BITS'(4);
   localparam logic [OPC_BITS-1:0] OP_RET    = OPC_BITS'(5);
   localparam logic [OPC_BITS-1:0] OP_HALT   = OPC_BITS'(6);

   localparam logic [1:0] CTL_INC  = 2'b00;
   localparam logic [1:0] CTL_IMM  = 2'b01;
   localparam logic [1:0] CTL_REG  = 2'b10;
   localparam logic [1:0] CTL_HOLD = 2'b11;

   typedef enum logic [2:0] {
      S_FETCH,
      S_EXEC,
      S_UPDATE,
      S_HALT,
      S_FAULT
   } state_t;

   state_t             state_q, state_d;
   logic               pc_latch_data_q, pc_latch_data_d;
   logic [1:0]         pc_ctl_q, pc_ctl_d;
   logic               ret_sel_q, ret_sel_d;
   logic [PC_BITS-1:0] ret_addr_q, ret_addr_d;
   logic [SP_BITS-1:0] sp_q, sp_d;
   logic               halted_q, halted_d;
   logic               fault_q, fault_d;
   logic [PC_BITS-1:0] stack_q [STACK_DEPTH];
   logic [PC_BITS-1:0] stack_d [STACK_DEPTH];

   // Decision is taken in EXEC and registered so it is presented during UPDATE;
   // every other state falls back to hold with no strobe.
   always_comb begin
      state_d         = state_q;
      pc_latch_data_d = 1'b0;
      pc_ctl_d        = CTL_HOLD;
      ret_sel_d       = 1'b0;
      ret_addr_d      = ret_addr_q;
      sp_d            = sp_q;
      halted_d        = halted_q;
      fault_d         = fault_q;
      stack_d         = stack_q;

      case (state_q)
         S_FETCH: begin
            if (bus.imem_ready) state_d = S_EXEC;
         end
         S_EXEC: begin
            state_d         = S_UPDATE;
            pc_latch_data_d = 1'b1;
            case (bus.opcode)
               OP_BRANCH: pc_ctl_d = bus.cond_true ? CTL_IMM : CTL_INC;
               OP_JMPI:   pc_ctl_d = CTL_IMM;
               OP_JMPR:   pc_ctl_d = CTL_REG;
               OP_CALL: begin
                  if (sp_q == SP_BITS'(STACK_DEPTH)) begin
                     state_d         = S_FAULT;
                     pc_latch_data_d = 1'b0;
                     fault_d         = 1'b1;
                  end else begin
                     pc_ctl_d                  = CTL_IMM;
                     // Return address wraps naturally at 2^PC_BITS.
                     stack_d[IDX_BITS'(sp_q)]  = bus.pc_in + PC_BITS'(1);
                     sp_d                      = sp_q + SP_BITS'(1);
                  end
               end
               OP_RET: begin
                  if (sp_q == '0) begin
                     state_d         = S_FAULT;
                     pc_latch_data_d = 1'b0;
                     fault_d         = 1'b1;
                  end else begin
                     pc_ctl_d   = CTL_REG;
                     ret_sel_d  = 1'b1;
                     ret_addr_d = stack_q[IDX_BITS'(sp_q - SP_BITS'(1))];
                     sp_d       = sp_q - SP_BITS'(1);
                  end
               end
               OP_HALT: begin
                  state_d         = S_HALT;
                  pc_latch_data_d = 1'b0;
                  halted_d        = 1'b1;
               end
               default:   pc_ctl_d = CTL_INC;   // ALU/NOP and reserved
            endcase
         end
         S_UPDATE: state_d = S_FETCH;
         S_HALT:   state_d = S_HALT;
         S_FAULT:  state_d = S_FAULT;
         default:  state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clka) begin
      if (reset) begin
         state_q         <= S_FETCH;
         pc_latch_data_q <= 1'b0;
         pc_ctl_q        <= CTL_HOLD;
         ret_sel_q       <= 1'b0;
         ret_addr_q      <= '0;
         sp_q            <= '0;
         halted_q        <= 1'b0;
         fault_q         <= 1'b0;
      end else begin
         state_q         <= state_d;
         pc_latch_data_q <= pc_latch_data_d;
         pc_ctl_q        <= pc_ctl_d;
         ret_sel_q       <= ret_sel_d;
         ret_addr_q      <= ret_addr_d;
         sp_q            <= sp_d;
         halted_q        <= halted_d;
         fault_q         <= fault_d;
         // Stack contents need no reset: sp=0 makes every slot dead.
         stack_q         <= stack_d;
      end
   end

   assign bus.ir_load       = (state_q == S_FETCH) && bus.imem_ready;
   assign bus.pc_latch_data = pc_latch_data_q;
   assign bus.pc_ctl        = pc_ctl_q;
   assign bus.ret_sel       = ret_sel_q;
   assign bus.ret_addr      = ret_addr_q;
   assign bus.sp            = sp_q;
   assign bus.halted        = halted_q;
   assign bus.fault         = fault_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - Directed self-checking bench for pc_sequencer
// Purpose: applies an instruction table and hand-written corner sequences,
//          comparing all sequencer outputs every cycle.
// Ports: none (top-level bench).
module tb_pc_sequencer;
   localparam logic [2:0] OP_ALU  = 3'd0;
   localparam logic [2:0] OP_BR   = 3'd1;
   localparam logic [2:0] OP_JMPI = 3'd2;
   localparam logic [2:0] OP_JMPR = 3'd3;
   localparam logic [2:0] OP_CALL = 3'd4;
   localparam logic [2:0] OP_RET  = 3'd5;
   localparam logic [2:0] OP_HALT = 3'd6;
   localparam logic [2:0] OP_RSV  = 3'd7;

   logic clka;
   logic reset;

   pc_sequencer_if #(.PC_BITS(6), .OPC_BITS(3), .STACK_DEPTH(4)) bus_if ();

   pc_sequencer #(.PC_BITS(6), .OPC_BITS(3), .STACK_DEPTH(4)) dut (
      .clka  (clka),
      .reset (reset),
      .bus   (bus_if)
   );

   initial clka = 1'b0;
   always #5 clka = ~clka;

   typedef struct {
      int         wait_cyc;   // FETCH cycles with imem_ready low
      logic [2:0] op;
      logic       cond;
      logic [5:0] pc;
      logic [1:0] ctl;        // expected on the UPDATE pulse
      logic       rsel;
      logic [5:0] raddr;
      logic [2:0] sp;
   } instr_t;

   int         n_vec;
   int         n_bad;
   logic [5:0] cur_raddr;
   logic [2:0] cur_sp;
   instr_t     tbl [$];

   function automatic instr_t mk(int w, logic [2:0] op, logic cond, logic [5:0] pc,
                                 logic [1:0] ctl, logic rsel, logic [5:0] raddr, logic [2:0] sp);
      instr_t r;
      r.wait_cyc = w; r.op = op; r.cond = cond; r.pc = pc;
      r.ctl = ctl; r.rsel = rsel; r.raddr = raddr; r.sp = sp;
      return r;
   endfunction

   // {ir_load, pc_latch_data, pc_ctl, ret_sel, ret_addr, sp, halted, fault}
   function automatic logic [15:0] ex(logic ir, logic lat, logic [1:0] ctl, logic rsel,
                                      logic [5:0] raddr, logic [2:0] sp, logic h, logic f);
      return {ir, lat, ctl, rsel, raddr, sp, h, f};
   endfunction

   task automatic tick;
      @(posedge clka);
      #1;
   endtask

   task automatic chk(input string name, input logic [15:0] exp);
      logic [15:0] got;
      #1;
      got = {bus_if.ir_load, bus_if.pc_latch_data, bus_if.pc_ctl, bus_if.ret_sel,
             bus_if.ret_addr, bus_if.sp, bus_if.halted, bus_if.fault};
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %b want %b (ir,lat,ctl,rsel,raddr,sp,halt,flt)",
                  name, $time, got, exp);
      end
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      bus_if.imem_ready = 1'b0;
      bus_if.opcode = OP_ALU;
      for (int i = 0; i < n; i++) begin
         tick();
         chk("reset", ex(0, 0, 2'b11, 0, 6'd0, 3'd0, 0, 0));
      end
      reset = 1'b0;
      cur_raddr = 6'd0;
      cur_sp = 3'd0;
   endtask

   // Leaves the bench one cycle before the next FETCH check point.
   task automatic run_fetch_exec(input instr_t r, input string tag);
      for (int w = 0; w < r.wait_cyc; w++) begin
         bus_if.imem_ready = 1'b0;
         chk({tag, "_wait"}, ex(0, 0, 2'b11, 0, cur_raddr, cur_sp, 0, 0));
         tick();
      end
      bus_if.imem_ready = 1'b1;
      bus_if.opcode = OP_ALU;
      chk({tag, "_fetch"}, ex(1, 0, 2'b11, 0, cur_raddr, cur_sp, 0, 0));
      tick();
      bus_if.opcode = r.op;
      bus_if.cond_true = r.cond;
      bus_if.pc_in = r.pc;
      chk({tag, "_exec"}, ex(0, 0, 2'b11, 0, cur_raddr, cur_sp, 0, 0));
      tick();
   endtask

   task automatic run_instr(input instr_t r, input string tag);
      run_fetch_exec(r, tag);
      bus_if.opcode = OP_ALU;
      chk({tag, "_update"}, ex(0, 1, r.ctl, r.rsel, r.raddr, r.sp, 0, 0));
      tick();
      cur_raddr = r.raddr;
      cur_sp = r.sp;
   endtask

   initial begin
      n_vec = 0;
      n_bad = 0;
      bus_if.imem_ready = 1'b0;
      bus_if.opcode = OP_ALU;
      bus_if.cond_true = 1'b0;
      bus_if.pc_in = 6'd0;
      reset = 1'b1;

      //          wait op       cond pc     ctl    rsel raddr  sp
      tbl.push_back(mk(0, OP_ALU,  0, 6'd0,  2'b00, 0, 6'd0,  3'd0));
      tbl.push_back(mk(0, OP_ALU,  0, 6'd0,  2'b00, 0, 6'd0,  3'd0));
      tbl.push_back(mk(0, OP_ALU,  0, 6'd0,  2'b00, 0, 6'd0,  3'd0));
      tbl.push_back(mk(5, OP_ALU,  0, 6'd0,  2'b00, 0, 6'd0,  3'd0));
      tbl.push_back(mk(0, OP_BR,   1, 6'd5,  2'b01, 0, 6'd0,  3'd0));
      tbl.push_back(mk(0, OP_BR,   0, 6'd5,  2'b00, 0, 6'd0,  3'd0));
      tbl.push_back(mk(0, OP_CALL, 0, 6'd10, 2'b01, 0, 6'd0,  3'd1));
      tbl.push_back(mk(0, OP_CALL, 0, 6'd63, 2'b01, 0, 6'd0,  3'd2));
      tbl.push_back(mk(0, OP_RET,  0, 6'd0,  2'b10, 1, 6'd0,  3'd1));
      tbl.push_back(mk(0, OP_RET,  0, 6'd0,  2'b10, 1, 6'd11, 3'd0));
      tbl.push_back(mk(0, OP_JMPI, 0, 6'd0,  2'b01, 0, 6'd11, 3'd0));
      tbl.push_back(mk(0, OP_JMPR, 0, 6'd0,  2'b10, 0, 6'd11, 3'd0));
      tbl.push_back(mk(0, OP_RSV,  0, 6'd0,  2'b00, 0, 6'd11, 3'd0));

      do_reset(2);
      foreach (tbl[i]) run_instr(tbl[i], $sformatf("tbl%0d", i));

      // Overflow: four pushes fill the stack, the fifth faults and parks.
      do_reset(1);
      for (int i = 0; i < 4; i++)
         run_instr(mk(0, OP_CALL, 0, 6'(i * 5), 2'b01, 0, 6'd0, 3'(i + 1)), "call_fill");
      run_fetch_exec(mk(0, OP_CALL, 0, 6'd40, 2'b01, 0, 6'd0, 3'd4), "call_ovf");
      for (int i = 0; i < 6; i++) begin
         chk("ovf_hold", ex(0, 0, 2'b11, 0, 6'd0, 3'd4, 0, 1));
         tick();
      end

      // Underflow straight after reset.
      do_reset(1);
      run_fetch_exec(mk(0, OP_RET, 0, 6'd0, 2'b10, 1, 6'd0, 3'd0), "ret_unf");
      for (int i = 0; i < 4; i++) begin
         chk("unf_hold", ex(0, 0, 2'b11, 0, 6'd0, 3'd0, 0, 1));
         tick();
      end

      // HALT: sticky, no pulses, imem_ready ignored.
      do_reset(1);
      run_fetch_exec(mk(0, OP_HALT, 0, 6'd0, 2'b00, 0, 6'd0, 3'd0), "halt");
      for (int i = 0; i < 10; i++) begin
         chk("halt_hold", ex(0, 0, 2'b11, 0, 6'd0, 3'd0, 1, 0));
         tick();
      end

      // Reset landing in EXEC of a CALL drops the push and empties the stack.
      do_reset(1);
      run_instr(mk(0, OP_CALL, 0, 6'd20, 2'b01, 0, 6'd0, 3'd1), "pre_call");
      bus_if.imem_ready = 1'b1;
      chk("rst_fetch", ex(1, 0, 2'b11, 0, 6'd0, 3'd1, 0, 0));
      tick();
      bus_if.opcode = OP_CALL;
      bus_if.pc_in = 6'd30;
      chk("rst_exec", ex(0, 0, 2'b11, 0, 6'd0, 3'd1, 0, 0));
      reset = 1'b1;
      tick();
      bus_if.imem_ready = 1'b0;
      chk("rst_in_exec", ex(0, 0, 2'b11, 0, 6'd0, 3'd0, 0, 0));
      reset = 1'b0;
      tick();
      chk("rst_after", ex(0, 0, 2'b11, 0, 6'd0, 3'd0, 0, 0));
      cur_raddr = 6'd0;
      cur_sp = 3'd0;
      run_instr(mk(0, OP_ALU, 0, 6'd0, 2'b00, 0, 6'd0, 3'd0), "post_rst_alu");
      run_fetch_exec(mk(0, OP_RET, 0, 6'd0, 2'b10, 1, 6'd0, 3'd0), "post_rst_ret");
      chk("post_rst_unf", ex(0, 0, 2'b11, 0, 6'd0, 3'd0, 0, 1));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
